// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared types for the per-slave AHB arbiter.
// Transfer/burst encodings, arbiter states and burst length helper.
package ahb_slave_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        BURST  = 2'd1,
        UNDEF  = 2'd2,
        LOCKED = 2'd3
    } arb_state_t;

    function automatic logic [3:0] burst_beats(input hburst_t hb);
        logic [3:0] n;
        unique case (hb)
            WRAP4, INCR4:   n = 4'd3;
            WRAP8, INCR8:   n = 4'd7;
            WRAP16, INCR16: n = 4'd15;
            default:        n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker.
// Searches from ptr+1 upward, wrapping; ptr itself is checked last.
module ahb_rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic found;
    int   k;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr_i) + i) % N;
            if (!found && req_i[k]) begin
                found    = 1'b1;
                win_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: registered one-hot address/data phase selects,
// round-robin, burst-aware, lock-aware, switching only on HREADY edges.
module ahb_slave_arbiter
    import ahb_slave_arbiter_pkg::*;
#(
    parameter int MASTER_NUM     = 4,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [MASTER_NUM-1:0]         hreq,
    input  logic [MASTER_NUM-1:0]         hlock,
    input  logic [1:0]                    htrans,
    input  logic [2:0]                    hburst,
    input  logic                          hready,
    output logic [MASTER_NUM-1:0]         hgrant,
    output logic [MASTER_NUM-1:0]         data_sel,
    output logic [$clog2(MASTER_NUM)-1:0] hmaster
);

    localparam int IW = $clog2(MASTER_NUM);
    localparam logic [MASTER_NUM-1:0] DEF_OH =
        {{(MASTER_NUM-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
    localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);

    arb_state_t            state_q, state_d;
    arb_state_t            burst_q, burst_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IW-1:0]         rr_q, rr_d;
    logic [IW-1:0]         hmaster_q, hmaster_d;
    logic [MASTER_NUM-1:0] grant_q, grant_d;
    logic [MASTER_NUM-1:0] dsel_q, dsel_d;

    logic [MASTER_NUM-1:0] win;
    logic [IW-1:0]         win_idx;
    logic                  any_req;
    htrans_t               ht;
    hburst_t               hb;

    assign ht = htrans_t'(htrans);
    assign hb = hburst_t'(hburst);

    ahb_rr_picker #(
        .N  (MASTER_NUM),
        .IW (IW)
    ) u_picker (
        .req_i (hreq),
        .ptr_i (rr_q),
        .win_o (win),
        .idx_o (win_idx),
        .any_o (any_req)
    );

    // burst_q tracks burst progress even while the lock holds the owner
    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        hmaster_d = hmaster_q;
        grant_d   = grant_q;
        dsel_d    = dsel_q;
        if (hready) begin
            dsel_d = grant_q;
            unique case (ht)
                NONSEQ: begin
                    cnt_d = burst_beats(hb);
                    if (hb == SINGLE) begin
                        burst_d = ARB;
                    end else if (hb == INCR) begin
                        burst_d = UNDEF;
                    end else begin
                        burst_d = BURST;
                    end
                end
                SEQ: begin
                    if (burst_q == BURST) begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q <= 4'd1) begin
                            cnt_d   = 4'd0;
                            burst_d = ARB;
                        end
                    end
                end
                BUSY: begin
                end
                IDLE: begin
                    burst_d = ARB;
                    cnt_d   = 4'd0;
                end
            endcase
            state_d = hlock[hmaster_q] ? LOCKED : burst_d;
            if (state_d == ARB) begin
                if (any_req) begin
                    grant_d   = win;
                    hmaster_d = win_idx;
                    rr_d      = win_idx;
                end else begin
                    grant_d   = DEF_OH;
                    hmaster_d = DEF_IDX;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ARB;
            burst_q   <= ARB;
            cnt_q     <= 4'd0;
            rr_q      <= DEF_IDX;
            hmaster_q <= DEF_IDX;
            grant_q   <= DEF_OH;
            dsel_q    <= DEF_OH;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            hmaster_q <= hmaster_d;
            grant_q   <= grant_d;
            dsel_q    <= dsel_d;
        end
    end

    assign hgrant   = grant_q;
    assign data_sel = dsel_q;
    assign hmaster  = hmaster_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter (MASTER_NUM=4, DEFAULT_MASTER=0).
// Hand-computed grant/data_sel/hmaster expectations per step.
module tb_ahb_slave_arbiter;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_BUSY   = 2'd1;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR   = 3'd1;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR16 = 3'd7;

    logic       HCLK;
    logic       HRESETn;
    logic [3:0] hreq;
    logic [3:0] hlock;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [3:0] data_sel;
    logic [1:0] hmaster;

    int n_chk;
    int n_fail;
    bit mon_en;

    ahb_slave_arbiter #(
        .MASTER_NUM     (4),
        .DEFAULT_MASTER (0)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .hreq     (hreq),
        .hlock    (hlock),
        .htrans   (htrans),
        .hburst   (hburst),
        .hready   (hready),
        .hgrant   (hgrant),
        .data_sel (data_sel),
        .hmaster  (hmaster)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    always @(negedge HCLK) begin
        if (mon_en) begin
            chk("onehot_hgrant", 32'($onehot(hgrant)), 32'd1);
            chk("onehot_data_sel", 32'($onehot(data_sel)), 32'd1);
        end
    end

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        mon_en  = 1'b0;
        HRESETn = 1'b1;
        hreq    = '0;
        hlock   = '0;
        htrans  = T_IDLE;
        hburst  = B_SINGLE;
        hready  = 1'b1;

        // asynchronous reset, no clock edge yet
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_hgrant", hgrant, 4'b0001);
        chk("rst_data_sel", data_sel, 4'b0001);
        chk("rst_hmaster", hmaster, 2'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        mon_en  = 1'b1;

        // rotation
        hreq   = 4'b1111;
        htrans = T_NONSEQ;
        hburst = B_SINGLE;
        step();
        chk("rot1_hgrant", hgrant, 4'b0010);
        chk("rot1_data_sel", data_sel, 4'b0001);
        chk("rot1_hmaster", hmaster, 2'd1);
        step();
        chk("rot2_hgrant", hgrant, 4'b0100);
        chk("rot2_data_sel", data_sel, 4'b0010);
        step();
        chk("rot3_hgrant", hgrant, 4'b1000);
        chk("rot3_data_sel", data_sel, 4'b0100);
        chk("rot3_hmaster", hmaster, 2'd3);
        step();
        chk("rot4_hgrant", hgrant, 4'b0001);
        chk("rot4_data_sel", data_sel, 4'b1000);

        // fixed burst hold with wait states
        hreq   = 4'b0010;
        htrans = T_IDLE;
        step();
        chk("bh_own_m1", hgrant, 4'b0010);
        hreq   = 4'b0110;
        htrans = T_NONSEQ;
        hburst = B_INCR4;
        step();
        chk("bh_nonseq", hgrant, 4'b0010);
        chk("bh_nonseq_dsel", data_sel, 4'b0010);
        htrans = T_SEQ;
        step();
        chk("bh_seq2", hgrant, 4'b0010);
        hready = 1'b0;
        step();
        chk("bh_wait1", hgrant, 4'b0010);
        step();
        chk("bh_wait2", hgrant, 4'b0010);
        chk("bh_wait2_dsel", data_sel, 4'b0010);
        hready = 1'b1;
        step();
        chk("bh_seq3", hgrant, 4'b0010);
        step();
        chk("bh_seq4_switch", hgrant, 4'b0100);
        chk("bh_seq4_hmaster", hmaster, 2'd2);
        chk("bh_seq4_dsel", data_sel, 4'b0010);
        htrans = T_IDLE;
        hreq   = 4'b0100;
        step();
        chk("bh_dsel_follow", data_sel, 4'b0100);

        // undefined-length INCR
        hreq = 4'b1000;
        step();
        chk("ud_own_m3", hgrant, 4'b1000);
        hreq   = 4'b1001;
        htrans = T_NONSEQ;
        hburst = B_INCR;
        step();
        chk("ud_nonseq", hgrant, 4'b1000);
        htrans = T_SEQ;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("ud_seq_hold", hgrant, 4'b1000);
        end
        htrans = T_BUSY;
        step();
        chk("ud_busy_hold", hgrant, 4'b1000);
        htrans = T_IDLE;
        step();
        chk("ud_idle_switch", hgrant, 4'b0001);
        chk("ud_idle_hmaster", hmaster, 2'd0);

        // lock
        hreq = 4'b0100;
        step();
        chk("lk_own_m2", hgrant, 4'b0100);
        hlock  = 4'b0100;
        hreq   = 4'b1111;
        htrans = T_NONSEQ;
        hburst = B_SINGLE;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("lk_hold", hgrant, 4'b0100);
        end
        hlock = 4'b0000;
        step();
        chk("lk_release", hgrant, 4'b1000);
        chk("lk_release_hmaster", hmaster, 2'd3);

        // reset in the middle of an INCR16
        hreq   = 4'b0010;
        htrans = T_IDLE;
        step();
        chk("rm_own_m1", hgrant, 4'b0010);
        hreq   = 4'b0110;
        htrans = T_NONSEQ;
        hburst = B_INCR16;
        step();
        htrans = T_SEQ;
        for (int i = 0; i < 6; i++) step();
        chk("rm_burst_hold", hgrant, 4'b0010);
        #1 HRESETn = 1'b0;
        #1;
        chk("rm_rst_hgrant", hgrant, 4'b0001);
        chk("rm_rst_data_sel", data_sel, 4'b0001);
        chk("rm_rst_hmaster", hmaster, 2'd0);
        #2 HRESETn = 1'b1;
        hreq   = 4'b0100;
        htrans = T_IDLE;
        step();
        chk("rm_after_m2", hgrant, 4'b0100);
        hreq   = 4'b0110;
        htrans = T_NONSEQ;
        hburst = B_SINGLE;
        step();
        chk("rm_arb_state", hgrant, 4'b0010);

        // no requests falls back to the default master
        hreq   = 4'b0000;
        htrans = T_IDLE;
        step();
        chk("noreq_default", hgrant, 4'b0001);
        chk("noreq_hmaster", hmaster, 2'd0);

        @(negedge HCLK);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
